// File: rtl/miriscv_int_ctrl_if.sv
// Request/handshake bundle between the peripherals, the CSR file, the core trap
// logic and the interrupt controller.
interface miriscv_int_ctrl_if;
  logic [31:0] int_req_i;
  logic [31:0] mie_i;
  logic        irq_ack_i;
  logic        irq_ret_i;
  logic        irq_o;
  logic [31:0] mcause_o;
  logic [31:0] int_fin_o;

  modport slave (
    input  int_req_i, mie_i, irq_ack_i, irq_ret_i,
    output irq_o, mcause_o, int_fin_o
  );

  modport master (
    output int_req_i, mie_i, irq_ack_i, irq_ret_i,
    input  irq_o, mcause_o, int_fin_o
  );
endinterface

// File: rtl/miriscv_int_ctrl.sv
// Single-level interrupt controller: masks 32 request lines, picks the lowest
// pending line, hands it to the core and pulses a one-hot completion after mret.
module miriscv_int_ctrl (
  input  logic                 clk_i,
  input  logic                 rst_i,
  miriscv_int_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    FIN     = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  id;
  logic        irq;
  logic [31:0] mcause;
  logic [31:0] int_fin;

  logic [31:0] pending;
  logic [4:0]  lowest;

  assign pending = bus.int_req_i & bus.mie_i;

  // Scan downwards so the last hit is the lowest-numbered pending line.
  always_comb begin
    lowest = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pending[i]) lowest = 5'(i);
    end
  end

  // Outputs are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      id      <= 5'd0;
      irq     <= 1'b0;
      mcause  <= 32'd0;
      int_fin <= 32'd0;
    end else begin
      int_fin <= 32'd0;
      case (state)
        IDLE: begin
          if (pending != 32'd0) begin
            state  <= REQ;
            id     <= lowest;
            irq    <= 1'b1;
            mcause <= {1'b1, 26'd0, lowest};
          end
        end
        REQ: begin
          if (bus.irq_ack_i) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end else if (!pending[id]) begin
            // Request withdrawn before the core took it: drop silently.
            state  <= IDLE;
            irq    <= 1'b0;
            mcause <= 32'd0;
          end
        end
        SERVICE: begin
          if (bus.irq_ret_i) begin
            state   <= FIN;
            int_fin <= 32'd1 << id;
          end
        end
        FIN: begin
          state  <= IDLE;
          mcause <= 32'd0;
        end
        default: begin
          state   <= IDLE;
          irq     <= 1'b0;
          mcause  <= 32'd0;
          int_fin <= 32'd0;
        end
      endcase
    end
  end

  assign bus.irq_o     = irq;
  assign bus.mcause_o  = mcause;
  assign bus.int_fin_o = int_fin;

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of the interrupt handshake.
module tb_miriscv_int_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  miriscv_int_ctrl_if bus();

  miriscv_int_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = nothing outstanding, 1 = offered to core, 2 = core in handler, 3 = completion cycle.
  int         m_phase = 0;
  int         m_line  = 0;

  function automatic int lowest_line(input logic [31:0] p);
    int l = -1;
    for (int i = 0; i < 32; i++) begin
      if (p[i] && l < 0) l = i;
    end
    return l;
  endfunction

  function automatic logic [31:0] exp_mcause();
    return (m_phase != 0) ? (32'h8000_0000 + 32'(m_line)) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_fin();
    return (m_phase == 3) ? (32'd1 << m_line) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".irq"},    32'(bus.irq_o), 32'(m_phase == 1));
    check({tag, ".mcause"}, bus.mcause_o,   exp_mcause());
    check({tag, ".fin"},    bus.int_fin_o,  exp_fin());
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked 1 time unit later.
  task automatic step(input string tag);
    logic [31:0] p;
    logic a, r;
    p = bus.int_req_i & bus.mie_i;
    a = bus.irq_ack_i;
    r = bus.irq_ret_i;
    @(posedge clk);
    if (!rst) begin
      if (m_phase == 0) begin
        if (p != 0) begin m_line = lowest_line(p); m_phase = 1; end
      end else if (m_phase == 1) begin
        if (a) m_phase = 2;
        else if (!p[m_line]) m_phase = 0;
      end else if (m_phase == 2) begin
        if (r) m_phase = 3;
      end else begin
        m_phase = 0;
      end
    end
    #1;
    check_model(tag);
  endtask

  task automatic pulse_ack(input string tag);
    bus.irq_ack_i = 1'b1; step(tag); bus.irq_ack_i = 1'b0;
  endtask

  task automatic pulse_ret(input string tag);
    bus.irq_ret_i = 1'b1; step(tag); bus.irq_ret_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.int_req_i = '0; bus.mie_i = '0; bus.irq_ack_i = 1'b0; bus.irq_ret_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.irq", 32'(bus.irq_o), 32'd0);
    check("reset.mcause", bus.mcause_o, 32'd0);
    check("reset.fin", bus.int_fin_o, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Single interrupt on line 5
    bus.mie_i = 32'hFFFF_FFFF;
    bus.int_req_i[5] = 1'b1;
    step("single.req");
    check("single.irq_rise", 32'(bus.irq_o), 32'd1);
    check("single.mcause", bus.mcause_o, 32'h8000_0005);
    step("single.wait");
    pulse_ack("single.ack");
    check("single.irq_fall", 32'(bus.irq_o), 32'd0);
    step("single.svc1"); step("single.svc2");
    pulse_ret("single.ret");
    check("single.fin", bus.int_fin_o, 32'h0000_0020);
    bus.int_req_i[5] = 1'b0;
    step("single.after");
    check("single.fin_once", bus.int_fin_o, 32'd0);
    repeat (3) step("single.quiet");
    check("single.no_reirq", 32'(bus.irq_o), 32'd0);

    // Priority between lines 3 and 9
    bus.int_req_i = (32'd1 << 3) | (32'd1 << 9);
    step("prio.req");
    check("prio.first", bus.mcause_o, 32'h8000_0003);
    pulse_ack("prio.ack3");
    pulse_ret("prio.ret3");
    check("prio.fin3", bus.int_fin_o, 32'h0000_0008);
    bus.int_req_i[3] = 1'b0;
    step("prio.idle");
    step("prio.rearb");
    check("prio.irq9", 32'(bus.irq_o), 32'd1);
    check("prio.second", bus.mcause_o, 32'h8000_0009);
    pulse_ack("prio.ack9");
    pulse_ret("prio.ret9");
    bus.int_req_i[9] = 1'b0;
    repeat (2) step("prio.drain");

    // Masking
    bus.mie_i = 32'hFFFF_FFDF;
    bus.int_req_i[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("mask.hold");
      check("mask.irq_low", 32'(bus.irq_o), 32'd0);
    end
    bus.mie_i[5] = 1'b1;
    step("mask.enable");
    check("mask.irq_rise", 32'(bus.irq_o), 32'd1);
    pulse_ack("mask.ack");
    pulse_ret("mask.ret");
    bus.int_req_i[5] = 1'b0;
    repeat (2) step("mask.drain");

    // Cancel in REQ, then drop coinciding with ack
    bus.int_req_i[7] = 1'b1;
    step("cancel.req");
    bus.int_req_i[7] = 1'b0;
    step("cancel.drop");
    check("cancel.irq_fall", 32'(bus.irq_o), 32'd0);
    check("cancel.mcause", bus.mcause_o, 32'd0);
    repeat (3) step("cancel.quiet");
    bus.int_req_i[7] = 1'b1;
    step("race.req");
    bus.int_req_i[7] = 1'b0;
    pulse_ack("race.ack_drop");
    check("race.service", bus.mcause_o, 32'h8000_0007);
    step("race.svc");
    pulse_ret("race.ret");
    check("race.fin", bus.int_fin_o, 32'h0000_0080);
    repeat (2) step("race.drain");

    // Spurious handshakes
    pulse_ret("spur.ret_idle");
    check("spur.idle_fin", bus.int_fin_o, 32'd0);
    bus.int_req_i[4] = 1'b1;
    step("spur.req");
    pulse_ret("spur.ret_req");
    check("spur.still_req", 32'(bus.irq_o), 32'd1);
    pulse_ack("spur.ack");
    pulse_ack("spur.ack_svc");
    check("spur.svc_hold", bus.mcause_o, 32'h8000_0004);
    check("spur.svc_nofin", bus.int_fin_o, 32'd0);
    pulse_ret("spur.ret");
    check("spur.fin", bus.int_fin_o, 32'h0000_0010);
    bus.int_req_i[4] = 1'b0;
    repeat (2) step("spur.drain");

    // Asynchronous reset mid-service
    bus.int_req_i[2] = 1'b1;
    step("rst.req");
    pulse_ack("rst.ack");
    #2;
    rst = 1'b1;
    #1;
    m_phase = 0; m_line = 0;
    check("rst.async_irq", 32'(bus.irq_o), 32'd0);
    check("rst.async_mcause", bus.mcause_o, 32'd0);
    check("rst.async_fin", bus.int_fin_o, 32'd0);
    @(negedge clk); rst = 1'b0;
    step("rst.rearm");
    check("rst.reirq", 32'(bus.irq_o), 32'd1);
    check("rst.mcause", bus.mcause_o, 32'h8000_0002);
    pulse_ack("rst.ack2");
    pulse_ret("rst.ret2");
    bus.int_req_i[2] = 1'b0;
    repeat (2) step("rst.drain");

    // Randomized traffic; peripherals drop their line on the completion pulse
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) bus.int_req_i[$urandom_range(0, 31)] = 1'b1;
      if ($urandom_range(0, 15) == 0) bus.int_req_i[$urandom_range(0, 31)] = 1'b0;
      bus.mie_i     = ($urandom_range(0, 3) == 0) ? $urandom() : 32'hFFFF_FFFF;
      bus.irq_ack_i = ($urandom_range(0, 2) == 0);
      bus.irq_ret_i = ($urandom_range(0, 2) == 0);
      step("rand");
      if (m_phase == 3) bus.int_req_i[m_line] = 1'b0;
    end
    bus.irq_ack_i = 1'b0;
    bus.irq_ret_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miriscv_int_ctrl.md
# miriscv_int_ctrl

Interrupt controller between the 32 peripheral interrupt request lines and the miriscv core's trap logic. It masks the request lines with the CSR `mie` value and selects the lowest-numbered pending line. It raises a single interrupt to the core with a ready-made `mcause` value, waits for the core to take and then return from the trap, and finally emits a one-cycle one-hot completion pulse on `int_fin_o` so the requesting peripheral can drop its request. Only one interrupt is serviced at a time; there is no nesting.

## Interface
- No parameters; the line count is fixed at 32.
- clk_i  in  1  system clock, rising-edge
- rst_i  in  1  asynchronous reset, active-high
- int_req_i  in  32  level-sensitive requests; bit n is line n
- mie_i  in  32  enable mask from the CSR file; bit n enables line n
- irq_ack_i  in  1  core has entered the trap handler; single-cycle pulse
- irq_ret_i  in  1  core executed `mret`; single-cycle pulse
- irq_o  out  1  interrupt request to the core
- mcause_o  out  32  cause for the core: {1'b1, 26'b0, id[4:0]}
- int_fin_o  out  32  one-hot completion pulse back to the peripherals

## Operation
- pending = int_req_i & mie_i, combinational.
- id is a 5-bit register holding the index of the lowest set bit of pending, captured when the request is accepted.
- The FSM has four states: IDLE, REQ, SERVICE, FIN.
  - IDLE: if pending != 0 at the clock edge, capture id and go to REQ. Otherwise stay in IDLE.
  - REQ: irq_o = 1.
    - irq_ack_i = 1: go to SERVICE.
    - Else, if pending[id] = 0 (line dropped or masked): cancel and go to IDLE.
    - If irq_ack_i and the drop occur in the same cycle, the ack wins.
  - SERVICE: irq_o = 0. If irq_ret_i = 1, go to FIN.
  - FIN: int_fin_o = 32'b1 << id for exactly this cycle, then go to IDLE unconditionally.
- mcause_o is valid in REQ, SERVICE and FIN. It is 0 in IDLE.
- irq_o, int_fin_o and mcause_o are decoded from registered state and id only. They have no combinational path from any input.
- Changes to int_req_i or mie_i during SERVICE or FIN are ignored. Pending lines are re-arbitrated in IDLE.
- irq_ack_i is ignored outside REQ. irq_ret_i is ignored outside SERVICE.
- A line that is still asserted after its FIN cycle is re-accepted as a fresh interrupt. Peripherals must drop their request within one cycle of seeing int_fin_o.

## Timing
- Reset (rst_i = 1, asynchronous, may occur at any time including mid-service):
  - state = IDLE, id = 0
  - irq_o = 0, mcause_o = 0, int_fin_o = 0
  - No int_fin_o pulse is produced for an interrupt that was aborted by reset.
- Request to irq_o: 1 cycle. If pending becomes nonzero before edge E, irq_o is high after E.
- Ack to irq_o low: irq_o falls after the edge on which irq_ack_i is sampled.
- irq_ret_i to int_fin_o: int_fin_o is high for the one cycle after the edge that samples irq_ret_i.
- FIN to next acceptance: the earliest new irq_o rises 2 edges after the FIN pulse begins (FIN to IDLE, then IDLE to REQ).
- Minimum full cycle time (request, ack, ret, fin): 4 cycles with back-to-back ack and ret.

## Test plan
- Single interrupt, line 5:
  - Stimulus: mie_i = 32'hFFFF_FFFF; raise int_req_i[5]; pulse irq_ack_i 2 cycles later; pulse irq_ret_i 3 cycles after that.
  - Required: irq_o high 1 cycle after the request; mcause_o = 32'h8000_0005; int_fin_o = 32'h0000_0020 for exactly 1 cycle after ret. Bench clears int_req_i[5] on the fin pulse; no second irq_o follows.
- Priority:
  - Stimulus: raise lines 3 and 9 on the same cycle.
  - Required: mcause_o = 32'h8000_0003 first. After FIN, with line 9 still high, irq_o re-asserts with mcause_o = 32'h8000_0009.
- Masking:
  - Stimulus: mie_i = 32'hFFFF_FFDF, raise int_req_i[5]. Later set mie_i[5] = 1.
  - Required: irq_o stays 0 for 10 cycles while masked; irq_o rises 1 cycle after the enable.
- Cancel in REQ:
  - Stimulus: raise int_req_i[7], then drop it before any ack. In a second run, drop it on the same cycle as irq_ack_i.
  - Required: first run, irq_o falls and int_fin_o never pulses. Second run, the FSM proceeds to SERVICE and int_fin_o[7] pulses after ret.
- Spurious handshakes:
  - Stimulus: pulse irq_ret_i while in IDLE or REQ; pulse irq_ack_i while in SERVICE.
  - Required: no state change and no int_fin_o pulse.
- Reset mid-service:
  - Stimulus: assert rst_i asynchronously between clock edges while in SERVICE for line 2.
  - Required: all outputs are 0 immediately, before the next clock edge. With int_req_i[2] still high after release, irq_o re-asserts 1 cycle later with mcause_o = 32'h8000_0002.
